fpu_mul_sched: RTL and testbench

//   Shares one fixed-latency FP32 multiplier datapath (judge/mul/normalize/result chain) between two requesters.

---
 rtl/fpu_mul_sched.sv | 143 ++++++++++++++
 tb/tb_fpu_mul_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_sched.sv
// fpu_mul_sched: shares one fixed-latency FP32 multiplier between two requesters and queues the results.
// Define FPU_SCHED_RR_EN for round-robin arbitration. The default build uses fixed priority (req0 wins).
module fpu_mul_sched #(
   parameter int MUL_LAT   = 3,
   parameter int OUT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        mul_en,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_c,
   input  logic        mul_flag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_c,
   output logic        rsp_flag
);
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);
   localparam int PTR_W = $clog2(OUT_DEPTH);
   localparam int ENT_W = 34;

   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     occupied;
   logic               space_ok;
   logic               grant0;
   logic               grant1;
   logic               issue;
   logic               retire;
   logic               pop;
   logic [MUL_LAT-1:0] trk_v;
   logic [MUL_LAT-1:0] trk_id;
   logic [ENT_W-1:0]   fifo_mem [OUT_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   // Every accepted op owns a FIFO slot until popped, so retire can never overflow the FIFO.
   assign occupied = {1'b0, fifo_count} + {1'b0, inflight};
   assign space_ok = !rst && (occupied < (CNT_W+1)'(OUT_DEPTH));

`ifdef FPU_SCHED_RR_EN
   logic last_grant;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (space_ok) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (grant0 || grant1)
         last_grant <= grant1;
   end
`else
   // Fixed priority: requester 1 can starve while requester 0 keeps valid high.
   always_comb begin
      grant0 = space_ok && req0_valid;
      grant1 = space_ok && req1_valid && !req0_valid;
   end
`endif

   assign issue      = grant0 || grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign mul_en     = issue;
   assign mul_a      = grant0 ? req0_a : (grant1 ? req1_a : '0);
   assign mul_b      = grant0 ? req0_b : (grant1 ? req1_b : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_v  <= '0;
         trk_id <= '0;
      end else begin
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            trk_v[i]  <= trk_v[i-1];
            trk_id[i] <= trk_id[i-1];
         end
         trk_v[0]  <= issue;
         trk_id[0] <= grant1;
      end
   end

   assign retire = trk_v[MUL_LAT-1];
   assign pop    = rsp_valid && rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         inflight <= '0;
      else if (issue && !retire)
         inflight <= inflight + CNT_W'(1);
      else if (!issue && retire)
         inflight <= inflight - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (retire)
         fifo_mem[wr_ptr] <= {trk_id[MUL_LAT-1], mul_flag, mul_c};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (retire)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (retire && !pop)
            fifo_count <= fifo_count + CNT_W'(1);
         else if (!retire && pop)
            fifo_count <= fifo_count - CNT_W'(1);
      end
   end

   assign rsp_valid                 = (fifo_count != '0);
   assign {rsp_id, rsp_flag, rsp_c} = fifo_mem[rd_ptr];

   no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(retire && fifo_count == CNT_W'(OUT_DEPTH)));

endmodule

// File: tb/tb_fpu_mul_sched.sv
// tb_fpu_mul_sched: directed and random stimulus against a behavioural multiplier and scheduler model.
module tb_fpu_mul_sched;
   localparam int MUL_LAT   = 3;
   localparam int OUT_DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        mul_en;
   logic [31:0] mul_a, mul_b, mul_c;
   logic        mul_flag;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_flag;
   logic [31:0] rsp_c;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic        id;
      logic [32:0] res;
      int          due;
   } exp_t;
   exp_t scb[$];
   logic exp_last = 1'b1;

   fpu_mul_sched #(.MUL_LAT(MUL_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_flag(mul_flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
      .rsp_flag(rsp_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural FP32 multiply: truncating, denormals flushed to zero; result is {flag, value}.
   function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [47:0] prod;
      logic [22:0] frac;
      int          e;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {1'b1, 32'h7FC00000};
      if (a_inf || b_inf) return {1'b0, s, 8'hFF, 23'h0};
      if (a_zero || b_zero) return {1'b0, s, 31'h0};
      prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e    = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (prod[47]) begin
         frac = prod[46:24];
         e++;
      end else begin
         frac = prod[45:23];
      end
      if (e >= 255) return {1'b1, s, 8'hFF, 23'h0};
      if (e <= 0) return {1'b1, s, 31'h0};
      return {1'b0, s, e[7:0], frac};
   endfunction

   // Datapath stand-in: junk is shifted in on idle cycles so misaligned captures show up.
   logic [32:0] dp [MUL_LAT];
   always @(posedge clk) begin
      dp[0] <= mul_en ? fp_mul(mul_a, mul_b) : {1'b1, 32'hDEADBEEF};
      for (int i = 1; i < MUL_LAT; i++) dp[i] <= dp[i-1];
   end
   assign mul_c    = dp[MUL_LAT-1][31:0];
   assign mul_flag = dp[MUL_LAT-1][32];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scheduler model: every accepted op holds one of OUT_DEPTH slots until popped.
   always @(negedge clk) begin
      logic g0, g1, space, exp_rv;
      exp_t e;
      if (rst) begin
         scb.delete();
         exp_last = 1'b1;
         check_eq("rst_rsp_valid", rsp_valid, 0);
         check_eq("rst_mul_en", mul_en, 0);
         check_eq("rst_readys", {req1_ready, req0_ready}, 0);
      end else begin
         space = scb.size() < OUT_DEPTH;
         g0 = 1'b0;
         g1 = 1'b0;
         if (space) begin
`ifdef FPU_SCHED_RR_EN
            if (req0_valid && req1_valid) begin
               g0 = exp_last;
               g1 = !exp_last;
            end else begin
               g0 = req0_valid;
               g1 = req1_valid;
            end
`else
            g0 = req0_valid;
            g1 = req1_valid && !req0_valid;
`endif
         end
         check_eq("req0_ready", req0_ready, g0);
         check_eq("req1_ready", req1_ready, g1);
         check_eq("mul_en", mul_en, g0 | g1);
         check_eq("mul_a", mul_a, g0 ? req0_a : (g1 ? req1_a : 32'h0));
         check_eq("mul_b", mul_b, g0 ? req0_b : (g1 ? req1_b : 32'h0));
         exp_rv = (scb.size() > 0) && (scb[0].due <= cyc);
         check_eq("rsp_valid", rsp_valid, exp_rv);
         if (exp_rv && rsp_ready) begin
            e = scb.pop_front();
            check_eq("rsp_id", rsp_id, e.id);
            check_eq("rsp_c", rsp_c, e.res[31:0]);
            check_eq("rsp_flag", rsp_flag, e.res[32]);
         end
         if (g0 || g1) begin
            e.id  = g1;
            e.res = g1 ? fp_mul(req1_a, req1_b) : fp_mul(req0_a, req0_b);
            e.due = cyc + MUL_LAT + 1;
            scb.push_back(e);
            exp_last = g1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic id, input logic [31:0] c, input logic f);
      check_eq({tag, "_valid"}, rsp_valid, 1);
      check_eq({tag, "_id"}, rsp_id, id);
      check_eq({tag, "_c"}, rsp_c, c);
      check_eq({tag, "_flag"}, rsp_flag, f);
   endtask

   task automatic wait_rsp(input string tag, input logic id, input logic [31:0] c, input logic f);
      logic seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            check_rsp(tag, id, c, f);
            seen = 1'b1;
         end
         tick();
      end
      check_eq({tag, "_seen"}, seen, 1);
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      repeat (12) tick();
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] r = $urandom;
      case ($urandom_range(0, 3))
         0: return r;
         1: return {r[31], 8'd118 + 8'($urandom_range(0, 20)), r[22:0]};
         2: case ($urandom_range(0, 3))
               0: return 32'h00000000;
               1: return 32'h7F800000;
               2: return 32'h7FC00000;
               default: return 32'h3F800000;
            endcase
         default: return {r[31], 8'd125 + 8'($urandom_range(0, 5)), r[22:0]};
      endcase
   endfunction

   initial begin
      int   n_acc;
      int   n_g;
      logic exp_id;
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // 3.0 * 2.0 from requester 0
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h40000000;
      tick();
      req0_valid = 1'b0;
      wait_rsp("t1", 1'b0, 32'h40C00000, 1'b0);
      drain();

      // Contention: round-robin alternates starting with req1 (req0 won last), fixed gives req0
      req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h3F800000;
      req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h3F800000;
      n_g = 0;
`ifdef FPU_SCHED_RR_EN
      exp_id = 1'b1;
`else
      exp_id = 1'b0;
`endif
      repeat (8) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            check_eq("t2_grant_id", req1_ready, exp_id);
            n_g++;
`ifdef FPU_SCHED_RR_EN
            exp_id = !exp_id;
`endif
         end
         tick();
      end
      check_eq("t2_enough_grants", n_g >= 4, 1);
      drain();

      // Back-pressure: FIFO fills, issue stops, resumes the cycle after the first pop
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 32'h3FC00000; req1_b = 32'h3FC00000;
      n_acc = 0;
      repeat (10) begin
         @(negedge clk);
         if (req1_ready) n_acc++;
         tick();
      end
      check_eq("t3_accepted", n_acc, 4);
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("t3_stall_on_pop", req1_ready, 0);
      check_rsp("t3_r0", 1'b1, 32'h40100000, 1'b0);
      tick();
      @(negedge clk);
      check_eq("t3_resume", req1_ready, 1);
      check_rsp("t3_r1", 1'b1, 32'h40100000, 1'b0);
      tick();
      req1_valid = 1'b0;
      wait_rsp("t3_r2", 1'b1, 32'h40100000, 1'b0);
      wait_rsp("t3_r3", 1'b1, 32'h40100000, 1'b0);
      drain();

      // Reset with two ops in flight; requester 0 holds a new op through reset
      req0_valid = 1; req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
      repeat (2) tick();
      rst = 1'b1;
      req0_a = 32'h40000000; req0_b = 32'h40000000;
      tick();
      rst = 1'b0;
      tick();
      req0_valid = 1'b0;
      wait_rsp("t5_new", 1'b0, 32'h40800000, 1'b0);
      drain();

      // inf * 0 from requester 1
      req1_valid = 1; req1_a = 32'h7F800000; req1_b = 32'h00000000;
      tick();
      req1_valid = 1'b0;
      wait_rsp("t6_inf_zero", 1'b1, 32'h7FC00000, 1'b1);
      drain();

      // Random traffic with random back-pressure
      repeat (400) begin
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_a = rand_op(); req0_b = rand_op();
         req1_a = rand_op(); req1_b = rand_op();
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
